hazard_sched_ctrl: RTL and testbench
====================================

Name: hazard_sched_ctrl

Overview:
- Pipeline control scheduler for the 5-stage RV32I core.
- Selects EX-stage operand forwarding, detects load-use hazards, and flushes on taken branches and jumps.
- Sequences the multi-cycle mul/div unit through a start/done handshake with a watchdog timeout.
- Counts stall cycles for performance monitoring.
- Drives stall and flush enables for the IF/ID/EX/MEM pipeline registers that carry the decoded immediate and operands.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- MD_TIMEOUT, 64, maximum cycles in BUSY before the watchdog aborts; must be at least 2.
- CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- Rs1_D  in  5  rs1 index of the instruction in ID.
- Rs2_D  in  5  rs2 index of the instruction in ID.
- Rs1_E  in  5  rs1 index of the instruction in EX.
- Rs2_E  in  5  rs2 index of the instruction in EX.
- Rd_E  in  5  rd index in EX.
- Rd_M  in  5  rd index in MEM.
- Rd_W  in  5  rd index in WB.
- RegWrite_M  in  1  MEM-stage instruction writes rd.
- RegWrite_W  in  1  WB-stage instruction writes rd.
- Load_E  in  1  EX-stage instruction is a load.
- PCSrc_E  in  1  taken branch, JAL or JALR resolved in EX.
- MdStart_E  in  1  multi-cycle mul/div op present in EX (level).
- MdDone  in  1  mul/div unit result valid (single-cycle pulse).
- ForwardA_E  out  2  operand A select: 00 register file, 01 WB result, 10 MEM ALU result.
- ForwardB_E  out  2  operand B select, same encoding as ForwardA_E.
- Stall_F  out  1  hold PC.
- Stall_D  out  1  hold IF/ID register.
- Stall_E  out  1  hold ID/EX register.
- Flush_D  out  1  clear IF/ID register.
- Flush_E  out  1  clear ID/EX register.
- Flush_M  out  1  insert a bubble into EX/MEM.
- MdBusy  out  1  FSM is in BUSY.
- MdTimeout  out  1  sticky watchdog error flag.
- StallCount  out  CNT_WIDTH  count of cycles with Stall_F=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - While rst=1, every output is forced to 0.
  - On the next edge the FSM is in RUN, the timeout counter is 0, MdTimeout is 0 and StallCount is 0.
  - A reset asserted while in BUSY aborts the op; all stalls are low in the first cycle after rst deasserts.
- Forwarding (combinational, RUN and BUSY):
  - ForwardA_E=10 if RegWrite_M and Rd_M!=0 and Rd_M==Rs1_E.
  - Else ForwardA_E=01 if RegWrite_W and Rd_W!=0 and Rd_W==Rs1_E.
  - Else ForwardA_E=00.
  - MEM has priority over WB. ForwardB_E is identical using Rs2_E.
- Load-use: lwStall = Load_E and Rd_E!=0 and (Rd_E==Rs1_D or Rd_E==Rs2_D).
- Control generation in RUN:
  - If PCSrc_E: Flush_D=1, Flush_E=1, all stalls 0. PCSrc_E overrides lwStall because the dependent instruction is discarded.
  - Else if MdStart_E and not MdDone: Stall_F=Stall_D=Stall_E=1 and Flush_M=1. The next state is BUSY and the timeout counter is cleared.
  - Else if lwStall: Stall_F=Stall_D=1, Flush_E=1.
  - MdStart_E with MdDone in the same cycle produces no stall and the FSM stays in RUN.
- Control generation in BUSY:
  - MdBusy=1. Stall_F/D/E and Flush_M are asserted equal to ~MdDone.
  - PCSrc_E and lwStall are ignored; EX is occupied by the mul/div op.
  - MdDone=1: stalls drop in that same cycle and the next state is RUN.
  - Otherwise the counter increments. When the counter reaches MD_TIMEOUT-1 without MdDone: MdTimeout is set (sticky until rst), the next state is RUN, and stalls drop in the following cycle.
- StallCount: increments on every edge where Stall_F=1. It saturates at all-ones and does not wrap.
- Latency: all stall, flush and forward outputs are combinational from the current state and inputs. The only registered state is FSM, counter, MdTimeout and StallCount.

Test Plan:
- Forwarding: Rd_M=Rd_W=5, both RegWrite=1, Rs1_E=5 -> ForwardA_E=10. Drop RegWrite_M -> 01. Set Rd_M=Rd_W=0, Rs1_E=0 -> 00.
- Load-use: Load_E=1, Rd_E=7, Rs2_D=7 -> Stall_F=Stall_D=Flush_E=1 for exactly 1 cycle, StallCount 0→1. Same stimulus with Rd_E=0 -> no stall.
- Branch vs load-use: PCSrc_E=1 together with lwStall -> Flush_D=Flush_E=1, Stall_F=Stall_D=0.
- Mul/div: MdStart_E at cycle 0, MdDone at cycle 4 -> Stall_F/D/E=1 and Flush_M=1 in cycles 0–3, all 0 in cycle 4, MdBusy=1 in cycles 1–4, StallCount=4.
- Timeout: MD_TIMEOUT=8, MdStart_E held, MdDone never arrives -> MdTimeout rises after 8 BUSY cycles, the FSM returns to RUN, and MdTimeout stays 1 until rst.
- Reset mid-BUSY: rst pulsed on BUSY cycle 2 -> all outputs 0 during rst; state RUN, StallCount=0 and MdTimeout=0 afterwards.

Source files
------------

// File: rtl/hazard_sched_ctrl_if.sv
// Signal bundle between the RV32I pipeline datapath (master) and the hazard/scheduling controller (slave).
// Mul/div handshake: MdStart_E is a level held while the op sits in EX; MdDone is a one-cycle pulse, and the op retires in the cycle where both are high.
interface hazard_sched_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic                      RegWrite_M, RegWrite_W, Load_E, PCSrc_E, MdStart_E, MdDone;
  logic [1:0]                ForwardA_E, ForwardB_E;
  logic                      Stall_F, Stall_D, Stall_E;
  logic                      Flush_D, Flush_E, Flush_M;
  logic                      MdBusy, MdTimeout;
  logic [CNT_WIDTH-1:0]      StallCount;
  logic                      md_state;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
    output RegWrite_M, RegWrite_W, Load_E, PCSrc_E, MdStart_E, MdDone,
    input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
    input  Flush_D, Flush_E, Flush_M, MdBusy, MdTimeout, StallCount, md_state
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W,
    input  RegWrite_M, RegWrite_W, Load_E, PCSrc_E, MdStart_E, MdDone,
    output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E,
    output Flush_D, Flush_E, Flush_M, MdBusy, MdTimeout, StallCount, md_state
  );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Hazard and scheduling control for the 5-stage RV32I pipeline: forwarding, load-use stall,
// branch flush, mul/div sequencing with watchdog, and a saturating stall-cycle counter.
module hazard_sched_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MD_TIMEOUT     = 64,
  parameter int CNT_WIDTH      = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_sched_ctrl_if.slave hz
);

  localparam int TW = $clog2(MD_TIMEOUT);

  typedef enum logic {S_RUN = 1'b0, S_BUSY = 1'b1} state_t;

  state_t               state;
  logic [TW-1:0]        md_cnt;
  logic                 md_timeout;
  logic [CNT_WIDTH-1:0] stall_count;

  logic       lw_stall;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (hz.RegWrite_M && hz.Rd_M != REG_ADDR_WIDTH'(0) && hz.Rd_M == hz.Rs1_E)
      fwd_a = 2'b10;
    else if (hz.RegWrite_W && hz.Rd_W != REG_ADDR_WIDTH'(0) && hz.Rd_W == hz.Rs1_E)
      fwd_a = 2'b01;
    if (hz.RegWrite_M && hz.Rd_M != REG_ADDR_WIDTH'(0) && hz.Rd_M == hz.Rs2_E)
      fwd_b = 2'b10;
    else if (hz.RegWrite_W && hz.Rd_W != REG_ADDR_WIDTH'(0) && hz.Rd_W == hz.Rs2_E)
      fwd_b = 2'b01;
  end

  assign lw_stall = hz.Load_E && (hz.Rd_E != REG_ADDR_WIDTH'(0)) &&
                    ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));

  // In BUSY the EX slot belongs to the mul/div op, so branch and load-use are not evaluated.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    if (!rst) begin
      if (state == S_BUSY) begin
        stall_f = ~hz.MdDone;
        stall_d = ~hz.MdDone;
        stall_e = ~hz.MdDone;
        flush_m = ~hz.MdDone;
      end else if (hz.PCSrc_E) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (hz.MdStart_E && !hz.MdDone) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      md_cnt      <= '0;
      md_timeout  <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall_f && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      case (state)
        S_RUN: begin
          if (!hz.PCSrc_E && hz.MdStart_E && !hz.MdDone) begin
            state  <= S_BUSY;
            md_cnt <= '0;
          end
        end
        S_BUSY: begin
          if (hz.MdDone) begin
            state <= S_RUN;
          end else if (md_cnt == TW'(MD_TIMEOUT - 1)) begin
            // Watchdog abort: release the pipeline and latch the error until reset.
            md_timeout <= 1'b1;
            state      <= S_RUN;
          end else begin
            md_cnt <= md_cnt + 1'b1;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

  assign hz.ForwardA_E = rst ? 2'b00 : fwd_a;
  assign hz.ForwardB_E = rst ? 2'b00 : fwd_b;
  assign hz.Stall_F    = stall_f;
  assign hz.Stall_D    = stall_d;
  assign hz.Stall_E    = stall_e;
  assign hz.Flush_D    = flush_d;
  assign hz.Flush_E    = flush_e;
  assign hz.Flush_M    = flush_m;
  assign hz.MdBusy     = !rst && (state == S_BUSY);
  assign hz.MdTimeout  = !rst && md_timeout;
  assign hz.StallCount = rst ? CNT_WIDTH'(0) : stall_count;
  assign hz.md_state   = (state == S_BUSY);

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Bench for hazard_sched_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_hazard_sched_ctrl;
  localparam int TMO    = 8;
  localparam int CW     = 6;
  localparam int SC_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_sched_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) hz();

  hazard_sched_ctrl #(.REG_ADDR_WIDTH(5), .MD_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [1:0]    fa;
    logic [1:0]    fb;
    logic          sf, sd, se, fd, fe, fm, busy, to;
    logic [CW-1:0] sc;
  } obs_t;

  // Model state: busy flag, BUSY cycles spent without MdDone, sticky error, stall total.
  bit m_busy      = 1'b0;
  int m_busy_cyc  = 0;
  bit m_to        = 1'b0;
  int m_sc        = 0;

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (hz.RegWrite_M && hz.Rd_M != 0 && hz.Rd_M == rs) return 2'b10;
    if (hz.RegWrite_W && hz.Rd_W != 0 && hz.Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    bit   lw;
    e = '0;
    if (rst) return e;
    lw     = hz.Load_E && hz.Rd_E != 0 && (hz.Rd_E == hz.Rs1_D || hz.Rd_E == hz.Rs2_D);
    e.fa   = model_fwd(hz.Rs1_E);
    e.fb   = model_fwd(hz.Rs2_E);
    e.busy = m_busy;
    e.to   = m_to;
    e.sc   = CW'(m_sc);
    if (m_busy) begin
      if (!hz.MdDone) {e.sf, e.sd, e.se, e.fm} = 4'b1111;
    end else if (hz.PCSrc_E) begin
      {e.fd, e.fe} = 2'b11;
    end else if (hz.MdStart_E && !hz.MdDone) begin
      {e.sf, e.sd, e.se, e.fm} = 4'b1111;
    end else if (lw) begin
      {e.sf, e.sd, e.fe} = 3'b111;
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.fa = hz.ForwardA_E; a.fb = hz.ForwardB_E;
    a.sf = hz.Stall_F; a.sd = hz.Stall_D; a.se = hz.Stall_E;
    a.fd = hz.Flush_D; a.fe = hz.Flush_E; a.fm = hz.Flush_M;
    a.busy = hz.MdBusy; a.to = hz.MdTimeout; a.sc = hz.StallCount;
    return a;
  endfunction

  always @(posedge clk) begin : model_update
    obs_t e;
    e = model_out();
    if (rst) begin
      m_busy <= 1'b0; m_busy_cyc <= 0; m_to <= 1'b0; m_sc <= 0;
    end else begin
      if (e.sf && m_sc < SC_MAX) m_sc <= m_sc + 1;
      if (m_busy) begin
        if (hz.MdDone) m_busy <= 1'b0;
        else if (m_busy_cyc + 1 == TMO) begin m_to <= 1'b1; m_busy <= 1'b0; end
        else m_busy_cyc <= m_busy_cyc + 1;
      end else if (!hz.PCSrc_E && hz.MdStart_E && !hz.MdDone) begin
        m_busy <= 1'b1; m_busy_cyc <= 0;
      end
    end
  end

  task automatic clear_inputs();
    hz.Rs1_D = 0; hz.Rs2_D = 0; hz.Rs1_E = 0; hz.Rs2_E = 0;
    hz.Rd_E = 0; hz.Rd_M = 0; hz.Rd_W = 0;
    hz.RegWrite_M = 0; hz.RegWrite_W = 0; hz.Load_E = 0;
    hz.PCSrc_E = 0; hz.MdStart_E = 0; hz.MdDone = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a;
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    hz.Rs1_E = 5; hz.Rd_M = 5; hz.RegWrite_M = 1; hz.PCSrc_E = 1; hz.MdStart_E = 1;
    @(negedge clk);
    #1 a = sample();
    n_checks++;
    if (a !== obs_t'(0)) $display("FAIL reset_hold actual=%h expected=%h", a, obs_t'(0));
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1 a = sample();
    n_checks++;
    if (a !== obs_t'(0) || hz.md_state !== 1'b0)
      $display("FAIL reset_release actual=%h/%b expected=%h/0", a, hz.md_state, obs_t'(0));
    else n_pass++;
  endtask

  task automatic test_forwarding();
    do_reset();
    hz.Rd_M = 5; hz.Rd_W = 5; hz.RegWrite_M = 1; hz.RegWrite_W = 1; hz.Rs1_E = 5; hz.Rs2_E = 5;
    #1 n_checks++;
    if (hz.ForwardA_E !== 2'b10 || hz.ForwardB_E !== 2'b10)
      $display("FAIL fwd_mem actual=%b/%b expected=10/10", hz.ForwardA_E, hz.ForwardB_E);
    else n_pass++;
    hz.RegWrite_M = 0;
    #1 n_checks++;
    if (hz.ForwardA_E !== 2'b01 || hz.ForwardB_E !== 2'b01)
      $display("FAIL fwd_wb actual=%b/%b expected=01/01", hz.ForwardA_E, hz.ForwardB_E);
    else n_pass++;
    hz.RegWrite_M = 1; hz.Rd_M = 0; hz.Rd_W = 0; hz.Rs1_E = 0; hz.Rs2_E = 0;
    #1 n_checks++;
    if (hz.ForwardA_E !== 2'b00 || hz.ForwardB_E !== 2'b00)
      $display("FAIL fwd_x0 actual=%b/%b expected=00/00", hz.ForwardA_E, hz.ForwardB_E);
    else n_pass++;
    hz.Rd_M = 3; hz.Rd_W = 4; hz.Rs1_E = 4; hz.Rs2_E = 3;
    #1 n_checks++;
    if (hz.ForwardA_E !== 2'b01 || hz.ForwardB_E !== 2'b10)
      $display("FAIL fwd_split actual=%b/%b expected=01/10", hz.ForwardA_E, hz.ForwardB_E);
    else n_pass++;
  endtask

  task automatic test_load_use();
    do_reset();
    hz.Load_E = 1; hz.Rd_E = 7; hz.Rs2_D = 7;
    #1 n_checks++;
    if ({hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_E, hz.StallCount} !== {4'b1101, CW'(0)})
      $display("FAIL lw_stall actual=%b%b%b%b cnt=%0d expected=1101 cnt=0",
               hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_E, hz.StallCount);
    else n_pass++;
    @(negedge clk);
    clear_inputs();
    #1 n_checks++;
    if ({hz.Stall_F, hz.Flush_E, hz.StallCount} !== {2'b00, CW'(1)})
      $display("FAIL lw_release actual=%b%b cnt=%0d expected=00 cnt=1", hz.Stall_F, hz.Flush_E, hz.StallCount);
    else n_pass++;
    hz.Load_E = 1; hz.Rd_E = 0; hz.Rs2_D = 0;
    #1 n_checks++;
    if ({hz.Stall_F, hz.Stall_D, hz.Flush_E} !== 3'b000)
      $display("FAIL lw_x0 actual=%b%b%b expected=000", hz.Stall_F, hz.Stall_D, hz.Flush_E);
    else n_pass++;
  endtask

  task automatic test_branch_vs_load();
    do_reset();
    hz.Load_E = 1; hz.Rd_E = 7; hz.Rs1_D = 7; hz.PCSrc_E = 1;
    #1 n_checks++;
    if ({hz.Flush_D, hz.Flush_E, hz.Stall_F, hz.Stall_D} !== 4'b1100)
      $display("FAIL branch_over_lw actual=%b%b%b%b expected=1100",
               hz.Flush_D, hz.Flush_E, hz.Stall_F, hz.Stall_D);
    else n_pass++;
  endtask

  task automatic test_muldiv();
    do_reset();
    hz.MdStart_E = 1;
    for (int c = 0; c <= 4; c++) begin
      hz.MdDone = (c == 4);
      #1 n_checks++;
      if ({hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_M} !== {4{c != 4}} || hz.MdBusy !== (c >= 1))
        $display("FAIL md_cycle%0d actual=%b%b%b%b busy=%b expected=%b busy=%b", c,
                 hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_M, hz.MdBusy, {4{c != 4}}, c >= 1);
      else n_pass++;
      @(negedge clk);
    end
    clear_inputs();
    #1 n_checks++;
    if (hz.MdBusy !== 1'b0 || hz.StallCount !== CW'(4) || hz.Stall_F !== 1'b0)
      $display("FAIL md_after busy=%b cnt=%0d stall=%b expected busy=0 cnt=4 stall=0",
               hz.MdBusy, hz.StallCount, hz.Stall_F);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    hz.MdStart_E = 1;
    @(negedge clk);
    for (int k = 1; k <= TMO; k++) begin
      #1 n_checks++;
      if (hz.MdBusy !== 1'b1 || hz.MdTimeout !== 1'b0 || hz.Stall_F !== 1'b1)
        $display("FAIL to_busy%0d busy=%b to=%b stall=%b expected busy=1 to=0 stall=1",
                 k, hz.MdBusy, hz.MdTimeout, hz.Stall_F);
      else n_pass++;
      @(negedge clk);
    end
    hz.MdStart_E = 0;
    #1 n_checks++;
    if (hz.MdTimeout !== 1'b1 || hz.MdBusy !== 1'b0 || hz.Stall_F !== 1'b0 || hz.StallCount !== CW'(TMO + 1))
      $display("FAIL to_fire to=%b busy=%b stall=%b cnt=%0d expected to=1 busy=0 stall=0 cnt=%0d",
               hz.MdTimeout, hz.MdBusy, hz.Stall_F, hz.StallCount, TMO + 1);
    else n_pass++;
    repeat (3) @(negedge clk);
    #1 n_checks++;
    if (hz.MdTimeout !== 1'b1) $display("FAIL to_sticky actual=%b expected=1", hz.MdTimeout);
    else n_pass++;
  endtask

  // Entered with MdTimeout and StallCount already set, so the reset has something to clear.
  task automatic test_reset_mid_busy();
    obs_t a;
    hz.MdStart_E = 1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 a = sample();
    n_checks++;
    if (a !== obs_t'(0)) $display("FAIL rst_busy_hold actual=%h expected=%h", a, obs_t'(0));
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    hz.MdStart_E = 0;
    #1 a = sample();
    n_checks++;
    if (a !== obs_t'(0) || hz.md_state !== 1'b0)
      $display("FAIL rst_busy_after actual=%h/%b expected=%h/0", a, hz.md_state, obs_t'(0));
    else n_pass++;
  endtask

  task automatic test_saturation();
    do_reset();
    hz.MdStart_E = 1;
    repeat (SC_MAX + 8) @(negedge clk);
    hz.MdStart_E = 0;
    #1 n_checks++;
    if (hz.StallCount !== CW'(SC_MAX)) $display("FAIL sat_reach actual=%0d expected=%0d", hz.StallCount, SC_MAX);
    else n_pass++;
    hz.Load_E = 1; hz.Rd_E = 2; hz.Rs1_D = 2;
    @(negedge clk);
    clear_inputs();
    #1 n_checks++;
    if (hz.StallCount !== CW'(SC_MAX)) $display("FAIL sat_hold actual=%0d expected=%0d", hz.StallCount, SC_MAX);
    else n_pass++;
  endtask

  task automatic test_random();
    obs_t a, e;
    int   errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 59) == 0);
      hz.Rs1_D      = 5'($urandom_range(0, 3));
      hz.Rs2_D      = 5'($urandom_range(0, 3));
      hz.Rs1_E      = 5'($urandom_range(0, 3));
      hz.Rs2_E      = 5'($urandom_range(0, 3));
      hz.Rd_E       = 5'($urandom_range(0, 3));
      hz.Rd_M       = 5'($urandom_range(0, 3));
      hz.Rd_W       = 5'($urandom_range(0, 3));
      hz.RegWrite_M = $urandom_range(0, 1);
      hz.RegWrite_W = $urandom_range(0, 1);
      hz.Load_E     = ($urandom_range(0, 2) == 0);
      hz.PCSrc_E    = ($urandom_range(0, 5) == 0);
      hz.MdStart_E  = ($urandom_range(0, 3) == 0);
      hz.MdDone     = m_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) == 0);
      #1 a = sample();
      e = model_out();
      n_checks++;
      if (a !== e) begin
        if (errs < 10) $display("FAIL rand_cyc%0d actual=%h expected=%h", i, a, e);
        errs++;
      end else n_pass++;
      @(negedge clk);
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_load();
    test_muldiv();
    test_timeout();
    test_reset_mid_busy();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
